// File: rtl/gyro_pkg.sv
// gyro_pkg: shared types and width/limit helpers for the gyro rate integrator.
package gyro_pkg;

    // Integrator operating modes
    typedef enum logic [1:0] {
        ST_UNCAL = 2'd0,
        ST_CAL   = 2'd1,
        ST_RUN   = 2'd2
    } gyro_state_e;

    // Width of a per-channel calibration sum: the sample width plus headroom for 2^cal_log2 additions
    function automatic int cal_sum_width(input int in_w, input int cal_log2);
        return in_w + cal_log2;
    endfunction

    // Largest value a signed accumulator of width w can hold (w <= 64)
    function automatic logic signed [63:0] acc_max_f(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value a signed accumulator of width w can hold (w <= 64)
    function automatic logic signed [63:0] acc_min_f(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/gyro_int_chan.sv
// gyro_int_chan: one rate channel -- bias register, calibration sum,
// bias subtraction, dt scaling and angle accumulation.
// Build option GYRO_SAT_EN: clamp the accumulator and raise a sticky flag
// instead of wrapping on overflow.
module gyro_int_chan
    import gyro_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int ACC_W    = 24,
    parameter int DT       = 1,
    parameter int CAL_LOG2 = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  sample_i,
    input  logic             cal_clr_i,
    input  logic             cal_acc_i,
    input  logic             cal_fin_i,
    input  logic             integ_i,
    input  logic             clear_i,
    output logic [ACC_W-1:0] angle_o,
    output logic             sat_o
);

    localparam int SUM_W = cal_sum_width(IN_W, CAL_LOG2);
    localparam logic signed [ACC_W-1:0] DT_S = ACC_W'(DT);

    logic signed [IN_W-1:0]  sample_s;
    logic signed [IN_W-1:0]  bias_q, bias_d;
    logic signed [SUM_W-1:0] sum_q, sum_d, sum_add;
    logic signed [IN_W:0]    diff;
    logic signed [ACC_W-1:0] diff_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] angle_q, angle_d;
    logic signed [ACC_W-1:0] angle_upd;

    assign sample_s = sample_i;
    assign sum_add  = sum_q + {{CAL_LOG2{sample_s[IN_W-1]}}, sample_s};

    // Bias-corrected rate in IN_W+1 bits so the subtraction can never overflow
    assign diff     = {sample_s[IN_W-1], sample_s} - {bias_q[IN_W-1], bias_q};
    assign diff_ext = {{(ACC_W-IN_W-1){diff[IN_W]}}, diff};
    assign prod     = diff_ext * DT_S;

`ifdef GYRO_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max_f(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min_f(ACC_W));

    logic signed [ACC_W:0] acc_wide;
    logic                  ovf;
    logic                  sat_q, sat_d;

    // One extra bit exposes overflow: the top two bits disagree exactly when the sum left range
    assign acc_wide  = {angle_q[ACC_W-1], angle_q} + {prod[ACC_W-1], prod};
    assign ovf       = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
    assign angle_upd = ovf ? (acc_wide[ACC_W] ? ACC_MIN : ACC_MAX) : acc_wide[ACC_W-1:0];

    // Sticky flag: set on any clamped update, cleared when a calibration restarts
    always_comb begin
        sat_d = sat_q;
        if (cal_clr_i) begin
            sat_d = 1'b0;
        end else if (integ_i && !clear_i && ovf) begin
            sat_d = 1'b1;
        end
    end

    // Saturation flag register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;
`else
    assign angle_upd = angle_q + prod;
    assign sat_o     = 1'b0;
`endif

    // Next-state for sum, bias and angle; clear and calibration completion both zero the angle
    always_comb begin
        sum_d   = sum_q;
        bias_d  = bias_q;
        angle_d = angle_q;
        if (cal_clr_i) begin
            sum_d = '0;
        end else if (cal_acc_i) begin
            sum_d = sum_add;
        end
        if (cal_fin_i) begin
            bias_d = IN_W'(sum_add >>> CAL_LOG2);
        end
        if (clear_i || cal_fin_i) begin
            angle_d = '0;
        end else if (integ_i) begin
            angle_d = angle_upd;
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            bias_q  <= '0;
            angle_q <= '0;
        end else begin
            sum_q   <= sum_d;
            bias_q  <= bias_d;
            angle_q <= angle_d;
        end
    end

    assign angle_o = angle_q;

endmodule

// File: rtl/gyro_integrator.sv
// gyro_integrator: multi-axis gyro rate integrator with averaging bias
// calibration, clear, and output valid strobe. Channel 0 = pitch, 1 = roll,
// 2 = yaw. Build option GYRO_SAT_EN selects saturating accumulators.
module gyro_integrator
    import gyro_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int IN_W     = 16,
    parameter int ACC_W    = 24,
    parameter int DT       = 1,
    parameter int CAL_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic [NCH*IN_W-1:0]  sample_data,
    input  logic                 cal_start,
    input  logic                 clear,
    output logic [NCH*ACC_W-1:0] angle,
    output logic                 angle_valid,
    output logic                 cal_busy,
    output logic                 cal_done,
    output logic [NCH-1:0]       sat_flag
);

    gyro_state_e         state_q;
    logic [CAL_LOG2-1:0] cnt_q;
    logic                angle_valid_q;
    logic                cal_busy_q;
    logic                cal_done_q;

    logic integ;
    logic cal_acc;
    logic cal_fin;

    // Per-cycle channel controls; cal_start and clear both discard a coincident sample
    always_comb begin
        integ   = 1'b0;
        cal_acc = 1'b0;
        cal_fin = 1'b0;
        if (sample_valid && !cal_start) begin
            if (state_q == ST_CAL) begin
                cal_acc = 1'b1;
                cal_fin = &cnt_q;
            end else if (!clear) begin
                integ = 1'b1;
            end
        end
    end

    // Mode FSM with calibration counter and registered status strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_UNCAL;
            cnt_q         <= '0;
            angle_valid_q <= 1'b0;
            cal_busy_q    <= 1'b0;
            cal_done_q    <= 1'b0;
        end else begin
            angle_valid_q <= integ;
            if (cal_start) begin
                state_q    <= ST_CAL;
                cnt_q      <= '0;
                cal_busy_q <= 1'b1;
            end else if (cal_acc) begin
                cnt_q <= cnt_q + 1'b1;
                if (cal_fin) begin
                    state_q    <= ST_RUN;
                    cal_busy_q <= 1'b0;
                    cal_done_q <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            gyro_int_chan #(
                .IN_W     (IN_W),
                .ACC_W    (ACC_W),
                .DT       (DT),
                .CAL_LOG2 (CAL_LOG2)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .sample_i  (sample_data[gi*IN_W +: IN_W]),
                .cal_clr_i (cal_start),
                .cal_acc_i (cal_acc),
                .cal_fin_i (cal_fin),
                .integ_i   (integ),
                .clear_i   (clear),
                .angle_o   (angle[gi*ACC_W +: ACC_W]),
                .sat_o     (sat_flag[gi])
            );
        end
    endgenerate

    assign angle_valid = angle_valid_q;
    assign cal_busy    = cal_busy_q;
    assign cal_done    = cal_done_q;

endmodule

// File: tb/tb_gyro_integrator.sv
// tb_gyro_integrator: randomized scoreboard bench for gyro_integrator.
// Honours GYRO_SAT_EN in its reference model (clamp vs wrap).
module tb_gyro_integrator;

    localparam int NCH      = 3;
    localparam int IN_W     = 16;
    localparam int ACC_W    = 18;
    localparam int DT       = 1;
    localparam int CAL_LOG2 = 6;
    localparam int CAL_N    = 1 << CAL_LOG2;
    localparam int DW       = NCH * IN_W;
    localparam int AW       = NCH * ACC_W;
    localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACC_W - 1));

    logic          clk;
    logic          rst_n;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          cal_start;
    logic          clear;
    logic [AW-1:0] angle;
    logic          angle_valid;
    logic          cal_busy;
    logic          cal_done;
    logic [NCH-1:0] sat_flag;

    gyro_integrator #(
        .NCH      (NCH),
        .IN_W     (IN_W),
        .ACC_W    (ACC_W),
        .DT       (DT),
        .CAL_LOG2 (CAL_LOG2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .cal_start    (cal_start),
        .clear        (clear),
        .angle        (angle),
        .angle_valid  (angle_valid),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .sat_flag     (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state
    longint        m_angle[NCH];
    longint        m_bias[NCH];
    longint        m_sum[NCH];
    int            m_cnt;
    bit            m_cal;
    bit            m_done;
    bit [NCH-1:0]  m_sat;
    logic [AW-1:0] exp_q[$];

    function automatic logic [DW-1:0] pack3(input int a, input int b, input int c);
        logic [DW-1:0] d;
        d[0*IN_W +: IN_W] = IN_W'(a);
        d[1*IN_W +: IN_W] = IN_W'(b);
        d[2*IN_W +: IN_W] = IN_W'(c);
        return d;
    endfunction

    function automatic longint wrap_acc(input longint a);
        longint m;
        longint r;
        m = longint'(1) <<< ACC_W;
        r = ((a % m) + m) % m;
        if (r > AMAX) r = r - m;
        return r;
    endfunction

    function automatic longint floor_div(input longint s, input longint n);
        longint q;
        q = s / n;
        if (s < 0 && (s % n) != 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [AW-1:0] model_vec();
        logic [AW-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*ACC_W +: ACC_W] = ACC_W'(m_angle[k]);
        return v;
    endfunction

    function automatic longint dut_chan(input int k);
        logic signed [ACC_W-1:0] a;
        a = angle[k*ACC_W +: ACC_W];
        return longint'(a);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_angle[k] = 0;
            m_bias[k]  = 0;
            m_sum[k]   = 0;
        end
        m_cnt  = 0;
        m_cal  = 0;
        m_done = 0;
        m_sat  = '0;
        exp_q.delete();
    endtask

    // Apply the behavioural rules to one cycle of stimulus
    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic cs, input logic clr);
        logic signed [IN_W-1:0] s;
        longint a;
        if (clr) for (int k = 0; k < NCH; k++) m_angle[k] = 0;
        if (cs) begin
            m_cal = 1;
            m_cnt = 0;
            m_sat = '0;
            for (int k = 0; k < NCH; k++) m_sum[k] = 0;
        end else if (v && m_cal) begin
            for (int k = 0; k < NCH; k++) begin
                s = d[k*IN_W +: IN_W];
                m_sum[k] += longint'(s);
            end
            m_cnt++;
            if (m_cnt == CAL_N) begin
                for (int k = 0; k < NCH; k++) begin
                    m_bias[k]  = floor_div(m_sum[k], CAL_N);
                    m_angle[k] = 0;
                end
                m_cal  = 0;
                m_done = 1;
            end
        end else if (v && !clr) begin
            for (int k = 0; k < NCH; k++) begin
                s = d[k*IN_W +: IN_W];
                a = m_angle[k] + longint'(DT) * (longint'(s) - m_bias[k]);
`ifdef GYRO_SAT_EN
                if (a > AMAX) begin
                    a = AMAX;
                    m_sat[k] = 1'b1;
                end else if (a < AMIN) begin
                    a = AMIN;
                    m_sat[k] = 1'b1;
                end
`else
                a = wrap_acc(a);
`endif
                m_angle[k] = a;
            end
            exp_q.push_back(model_vec());
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic cs, input logic clr);
        sample_valid = v;
        sample_data  = d;
        cal_start    = cs;
        clear        = clr;
        model_step(v, d, cs, clr);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        cal_start    = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name);
        chk({name, "_angle"}, 64'(angle), 64'(model_vec()));
        chk({name, "_busy"}, 64'(cal_busy), 64'(m_cal));
        chk({name, "_done"}, 64'(cal_done), 64'(m_done));
        chk({name, "_sat"}, 64'(sat_flag), 64'(m_sat));
    endtask

    // Monitor: every angle_valid must match the oldest expected update
    always @(negedge clk) begin
        if (rst_n === 1'b1 && angle_valid === 1'b1) begin
            checks++;
            txn++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid angle %0h expected no update", angle);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                if (angle !== e) begin
                    errors++;
                    $display("FAIL angle_txn%0d actual %0h expected %0h", txn, angle, e);
                end else begin
                    $display("txn %0d angle %0h ok", txn, angle);
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        cal_start    = 1'b0;
        clear        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_status("reset");
        chk("reset_valid", 64'(angle_valid), 64'd0);

        // First sample in UNCAL integrates with zero bias
        drive(1'b1, pack3(100, -50, 0), 1'b0, 1'b0);
        chk("uncal_ch0", 64'(dut_chan(0)), 64'(100));
        chk("uncal_ch1", 64'(dut_chan(1)), 64'(-50));
        chk("uncal_valid", 64'(angle_valid), 64'd1);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("valid_one_cycle", 64'(angle_valid), 64'd0);

        // Random UNCAL traffic
        for (int i = 0; i < 12; i++)
            drive(1'($urandom_range(0, 3) != 0), DW'({$urandom, $urandom}), 1'b0, 1'b0);
        chk_status("uncal_rand");

        // clear with a coincident sample: angle zeroed, no strobe
        drive(1'b1, pack3(500, 500, 500), 1'b0, 1'b1);
        chk_status("clear_with_sample");
        chk("clear_valid", 64'(angle_valid), 64'd0);

        // cal_start with a coincident sample: sample dropped, CAL entered
        drive(1'b1, pack3(1000, 1000, 1000), 1'b1, 1'b0);
        chk_status("cal_enter");
        for (int i = 0; i < CAL_N; i++) drive(1'b1, pack3(10, -3, 0), 1'b0, 1'b0);
        chk_status("cal1_done");
        drive(1'b1, pack3(15, -3, 7), 1'b0, 1'b0);
        chk("run_ch0", 64'(dut_chan(0)), 64'(5));
        chk("run_ch1", 64'(dut_chan(1)), 64'(0));
        chk("run_ch2", 64'(dut_chan(2)), 64'(7));

        // Random RUN traffic with idle gaps and occasional clears
        for (int i = 0; i < 40; i++)
            drive(1'($urandom_range(0, 3) != 0), DW'({$urandom, $urandom}), 1'b0,
                  1'($urandom_range(0, 15) == 0));
        chk_status("run_rand");

        // Recalibration: ch0 alternates -1/0 giving floor(-32/64) = -1
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < CAL_N; i++)
            drive(1'b1, pack3((i % 2 == 0) ? -1 : 0, int'($urandom_range(0, 2000)) - 1000,
                              int'($urandom_range(0, 2000)) - 1000), 1'b0, 1'b0);
        chk_status("cal2_done");
        drive(1'b1, pack3(0, 0, 0), 1'b0, 1'b0);
        chk("floor_bias_ch0", 64'(dut_chan(0)), 64'(1));

        // Push channel 0 past full scale: clamp or wrap depending on build
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, pack3(32767, 0, 0), 1'b0, 1'b0);
        chk_status("overflow");
`ifdef GYRO_SAT_EN
        chk("sat_clamp_ch0", 64'(dut_chan(0)), 64'(AMAX));
`else
        chk("wrap_negative_ch0", 64'(dut_chan(0) < 0), 64'd1);
`endif

        // Reset in the middle of a calibration
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b1, DW'({$urandom, $urandom}), 1'b0, 1'b0);
        chk("midcal_busy", 64'(cal_busy), 64'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk_status("midcal_reset");
        drive(1'b1, pack3(-7, 9, 3), 1'b0, 1'b0);
        chk_status("post_reset_uncal");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
